// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a TX FIFO and a runtime baud divider
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] i_data,
    output logic [31:0] o_data,
    output logic        tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [15:0]   baud, div, cnt;
    logic [7:0]    shift;
    logic [2:0]    bit_cnt;
    logic [1:0]    idx;
    logic [31:0]   rdata;
    logic          ovf, sel, full, empty, busy, push_req, push, pop, done;
    logic          unused_bits;

    assign unused_bits = ^{addr[1:0], i_data[31:16]};
    assign sel      = addr[31:4] == BASE_ADDR[31:4];
    assign idx      = addr[3:2];
    assign full     = count == CW'(FIFO_DEPTH);
    assign empty    = count == '0;
    assign busy     = state != IDLE || !empty;
    assign push_req = wr && sel && idx == 2'd0;
    assign push     = push_req && !full;
    assign done     = cnt == div - 16'd1;

    always_comb begin
        rdata = idx == 2'd1 ? {24'd0, 4'(count), ovf, empty, full, busy} :
                idx == 2'd2 ? {16'd0, baud} : 32'd0;
    end

    // STOP pops straight into START so back-to-back frames have no idle gap
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        tx      = 1'b1;
        case (state)
            IDLE: begin
                pop     = !empty;
                state_n = empty ? IDLE : START;
            end
            START: begin
                tx      = 1'b0;
                state_n = done ? DATA : START;
            end
            DATA: begin
                tx      = shift[0];
                state_n = (done && bit_cnt == 3'd7) ? STOP : DATA;
            end
            STOP: begin
                pop     = done && !empty;
                state_n = !done ? STOP : empty ? IDLE : START;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= i_data[7:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            baud    <= 16'(CLKS_PER_BIT);
            div     <= 16'(CLKS_PER_BIT);
            cnt     <= '0;
            shift   <= '1;
            bit_cnt <= '0;
            o_data  <= '0;
        end else begin
            state  <= state_n;
            o_data <= (rd && sel) ? rdata : 32'd0;
            count  <= count + CW'(push) - CW'(pop);
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            if (push_req && full)
                ovf <= 1'b1;
            else if (wr && sel && idx == 2'd1 && i_data[3])
                ovf <= 1'b0;
            if (wr && sel && idx == 2'd2)
                baud <= i_data[15:0] == 16'd0 ? 16'd1 : i_data[15:0];
            // divider is sampled only when a frame starts
            if (pop) begin
                shift   <= mem[rd_ptr];
                div     <= baud;
                cnt     <= '0;
                bit_cnt <= '0;
            end else if (state != IDLE) begin
                cnt <= done ? 16'd0 : cnt + 16'd1;
                if (state == DATA && done) begin
                    shift   <= shift >> 1;
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
        end
    end
endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter peripheral and bus responder on the core data-memory interface. It decodes `addr`/`rd`/`wr` from the rv32 core alongside `memory`, accepts bytes into a small FIFO, and serialises them 8N1, LSB first, on `tx`. Read data is zero when the block is not addressed, so `o_data` can be OR-ed with the RAM read path in the SoC.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_1000, base address of the 16-byte register window (bits [3:0] ignored).
- `CLKS_PER_BIT`, 16, reset value of the baud divider register, legal range 1..65535.
- `FIFO_DEPTH`, 4, TX FIFO entries; power of two, 2..8.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `addr`  in  32  byte address from the core.
- `rd`  in  1  read strobe, one cycle per access.
- `wr`  in  1  write strobe, one cycle per access.
- `i_data`  in  32  write data from the core.
- `o_data`  out  32  read data to the core, registered.
- `tx`  out  1  serial output, idle high.

## Operation
- Select: `sel = (addr[31:4] == BASE_ADDR[31:4])`. Register index is `addr[3:2]`.
- Offset 0x0 TXDATA. A write pushes `i_data[7:0]` into the FIFO. If the FIFO is full, the byte is dropped and the sticky `ovf` bit is set. Reads return 0.
- Offset 0x4 STATUS (read). Fields:
  - bit0 `busy`: FSM not IDLE or FIFO non-empty.
  - bit1 `full`.
  - bit2 `empty`.
  - bit3 `ovf`.
  - bits[7:4] FIFO count.
  - All other bits 0.
  - Writing with `i_data[3]=1` clears `ovf`. Other written bits are ignored.
- Offset 0x8 BAUD. Read/write, `i_data[15:0]`; a write of 0 stores 1. Reads return the value zero-extended.
- Offset 0xC is reserved: reads return 0, writes have no effect.
- Unselected accesses have no effect on state.
- FSM states:
  - IDLE: `tx=1`. If the FIFO is non-empty, pop the head into the shift register, latch BAUD into the active divider, clear the bit counter, and go to START.
  - START: `tx=0` for `div` cycles, then DATA.
  - DATA: `tx=shift[0]` for `div` cycles per bit, shifting right. After 8 bits, go to STOP.
  - STOP: `tx=1` for `div` cycles. At the end, if the FIFO is non-empty, pop and latch the divider and go directly to START. Otherwise go to IDLE.
- Divider: latched only at frame start. A BAUD write mid-frame affects the next frame only.
- FIFO: circular with wrap-around pointers and a count register.
  - `full`/`empty` are evaluated on pre-edge count.
  - A push while full is dropped even if a pop occurs on the same edge.
  - A push and a pop on the same edge when not full leaves the count unchanged.
  - Pop is only issued when non-empty.
- Simultaneous `rd` and `wr` to the same register: the write takes effect and the read returns the pre-edge value.

## Timing
- Reset, on the first edge with `reset=0`:
  - FSM to IDLE, `tx=1`.
  - FIFO emptied, pointers 0.
  - `ovf=0`, BAUD=`CLKS_PER_BIT`.
  - `o_data=0`.
  - Any in-progress frame is aborted mid-bit; the line returns high immediately.
- Read latency is 1 cycle. On an edge with `rd && sel`, `o_data` takes the register value. On any other edge, `o_data` is 0.
- Write to TXDATA at edge k, with the FIFO empty and the FSM in IDLE:
  - The byte is in the FIFO after edge k.
  - Pop at edge k+1; `tx` goes low after edge k+1.
  - STATUS `busy` reads 1 from edge k onward.
- Frame length is exactly `10*div` cycles.
- Back-to-back frames have zero idle cycles: the start bit immediately follows the stop bit.
- `busy` falls on the edge where STOP ends with an empty FIFO.

## Test plan
- Reset, then read STATUS (0x1004) -> `o_data` = 0x0000_0004 one cycle later; `tx`=1. Read BAUD -> 16.
- BAUD=4, write TXDATA 0xA5 -> `tx` low 4 cycles starting the cycle after the pop edge, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles; total 40 cycles.
- BAUD=2, write 0x01, 0x02, 0x03, 0x04, 0x05 in 5 consecutive cycles while the first frame is not yet started:
  - 0x01 pops before 0x05 arrives, so all five are accepted, the count reaches 4, and `ovf` stays 0.
  - A sixth write before any further pop is dropped and `ovf`=1.
  - The line shows exactly five contiguous 20-cycle frames.
- Write BAUD=8 during a frame at BAUD=2 -> the current frame completes at 2 cycles/bit; the next frame runs at 8 cycles/bit.
- Assert `reset` low mid-DATA -> `tx`=1, STATUS=0x4, BAUD=16 after that edge; no further `tx` activity.
- Read 0x2000 (unselected) and 0x100C -> `o_data`=0. Write STATUS with `i_data`=0x8 after an overflow -> `ovf` clears.
